// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch prefetch queue sitting between the PC/instruction memory
// and the decode stage. Each fetched word is stored together with its
// next-PC (address + 1, word addressed). The queue tracks its own fill level,
// stalls the PC when full, drops everything on a taken branch (flush) and
// stops fetching for good once a HALT has been decoded.
//
// Optional feature: define IFQ_BYPASS_EN to let a word fetched into an empty
// queue appear on the decode outputs in the same cycle. If decode accepts it,
// the word is never written into the storage array.
//
// Parameters
//   NB_ADDR   instruction address width
//   NB_INSTR  instruction word width
//   DEPTH     number of entries (power of two, >= 2)
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_pc_addr    address currently held by the PC
//   i_instr      instruction memory read data for i_pc_addr
//   i_mem_valid  i_instr is valid this cycle
//   i_flush      taken branch/jump, discard queued instructions
//   i_halt       HALT decoded, stop fetching
//   i_id_ready   decode accepts the head entry
//   o_pc_enable  PC advance enable (one per pushed word)
//   o_id_valid   head entry valid
//   o_id_instr   head instruction (zero/NOP when empty)
//   o_id_npc     head entry address + 1 (zero when empty)
//   o_count      number of occupied entries
//   o_state      FSM state: 00 fetch, 01 stall, 10 flush, 11 halted
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int unsigned NB_ADDR  = 32,
  parameter int unsigned NB_INSTR = 32,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NB_ADDR-1:0]           i_pc_addr,
  input  logic [NB_INSTR-1:0]          i_instr,
  input  logic                         i_mem_valid,
  input  logic                         i_flush,
  input  logic                         i_halt,
  input  logic                         i_id_ready,
  output logic                         o_pc_enable,
  output logic                         o_id_valid,
  output logic [NB_INSTR-1:0]          o_id_instr,
  output logic [NB_ADDR-1:0]           o_id_npc,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic [1:0]                   o_state
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StFetch  = 2'b00,
    StStall  = 2'b01,
    StFlush  = 2'b10,
    StHalted = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  logic [NB_INSTR-1:0] instr_mem_q [DEPTH];
  logic [NB_ADDR-1:0]  npc_mem_q   [DEPTH];

  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                store;
  logic                pop_mem;
  logic                bypass_take;
  logic                id_valid;
  logic [NB_ADDR-1:0]  pc_npc;

  assign pc_npc = i_pc_addr + NB_ADDR'(1);
  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(DEPTH));

  // Push decision uses the registered fill level only, so a concurrent pop
  // never makes room for a push in the same cycle.
  assign push = (state_q == StFetch) && i_mem_valid && !full &&
                !i_flush && !i_halt && !i_reset;

`ifdef IFQ_BYPASS_EN
  assign id_valid    = !empty || push;
  // Word shown straight from memory and accepted: it never enters storage.
  assign bypass_take = empty && push && i_id_ready;
`else
  assign id_valid    = !empty;
  assign bypass_take = 1'b0;
`endif

  assign pop     = id_valid && i_id_ready && !i_flush;
  assign store   = push && !bypass_take;
  assign pop_mem = pop && !empty;

  // Pointer and occupancy next-state. Pointers wrap naturally at PtrW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop_mem) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({store, pop_mem})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FSM: state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state. Stall tracks the post-edge fill level so o_state and
  // o_count always agree. Flush lasts one cycle because the queue is empty
  // afterwards and nothing can be pushed while in flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StHalted: state_d = StHalted;
      default: begin
        if (i_flush) begin
          state_d = StFlush;
        end else if (i_halt) begin
          state_d = StHalted;
        end else if (count_d == CntW'(DEPTH)) begin
          state_d = StStall;
        end else begin
          state_d = StFetch;
        end
      end
    endcase
  end

  // Queue control registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are masked on the outputs when empty, so it
  // needs no reset.
  always_ff @(posedge i_clk) begin
    if (store) begin
      instr_mem_q[wr_ptr_q] <= i_instr;
      npc_mem_q[wr_ptr_q]   <= pc_npc;
    end
  end

  // FSM: outputs.
  always_comb begin
    o_pc_enable = push;
    o_id_valid  = id_valid;
    o_id_instr  = '0;
    o_id_npc    = '0;
    o_count     = count_q;
    o_state     = state_q;
    if (!empty) begin
      o_id_instr = instr_mem_q[rd_ptr_q];
      o_id_npc   = npc_mem_q[rd_ptr_q];
    end
`ifdef IFQ_BYPASS_EN
    else if (push) begin
      o_id_instr = i_instr;
      o_id_npc   = pc_npc;
    end
`endif
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_queue
//
// Scoreboard bench for if_prefetch_queue. The driver issues one cycle of
// stimulus at a time, keeps a queue-level reference model (a list of the
// entries that should be held, plus the fetch/stall/flush/halted mode) and
// pushes each expected entry into the scoreboard. A separate monitor pops
// the scoreboard on every decode handshake and compares the delivered word.
// ---------------------------------------------------------------------------
module tb_if_prefetch_queue;

  localparam int unsigned NB_ADDR  = 32;
  localparam int unsigned NB_INSTR = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CntW     = $clog2(DEPTH) + 1;
`ifdef IFQ_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic                i_clk;
  logic                i_reset;
  logic [NB_ADDR-1:0]  i_pc_addr;
  logic [NB_INSTR-1:0] i_instr;
  logic                i_mem_valid;
  logic                i_flush;
  logic                i_halt;
  logic                i_id_ready;
  logic                o_pc_enable;
  logic                o_id_valid;
  logic [NB_INSTR-1:0] o_id_instr;
  logic [NB_ADDR-1:0]  o_id_npc;
  logic [CntW-1:0]     o_count;
  logic [1:0]          o_state;

  if_prefetch_queue #(
    .NB_ADDR  (NB_ADDR),
    .NB_INSTR (NB_INSTR),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_pc_addr   (i_pc_addr),
    .i_instr     (i_instr),
    .i_mem_valid (i_mem_valid),
    .i_flush     (i_flush),
    .i_halt      (i_halt),
    .i_id_ready  (i_id_ready),
    .o_pc_enable (o_pc_enable),
    .o_id_valid  (o_id_valid),
    .o_id_instr  (o_id_instr),
    .o_id_npc    (o_id_npc),
    .o_count     (o_count),
    .o_state     (o_state)
  );

  typedef struct packed {
    logic [NB_INSTR-1:0] instr;
    logic [NB_ADDR-1:0]  npc;
  } entry_t;

  entry_t             sb[$];
  int                 checks = 0;
  int                 errors = 0;
  bit                 done = 1'b0;
  bit                 seen_reset = 1'b0;
  int                 m_st = 0;   // 0 fetch, 1 stall, 2 flush, 3 halted
  logic [NB_ADDR-1:0] pc = '0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the reference model update for that cycle.
  task automatic step(input bit rst, input bit mv, input bit fl, input bit hl, input bit rdy);
    int     size;
    int     nsize;
    bit     push;
    bit     valid;
    bit     pop;
    entry_t e;
    @(posedge i_clk);
    #1;
    i_reset     = rst;
    i_mem_valid = mv;
    i_flush     = fl;
    i_halt      = hl;
    i_id_ready  = rdy;
    i_pc_addr   = pc;
    i_instr     = $urandom;
    size  = sb.size();
    push  = (m_st == 0) && mv && (size < DEPTH) && !fl && !hl && !rst;
    valid = (size > 0) || (Bypass && push);
    #1;
    check("pc_enable", 64'(o_pc_enable), 64'(push));
    if (seen_reset) begin
      check("count", 64'(o_count), 64'(size));
      check("state", 64'(o_state), 64'(m_st));
      check("id_valid", 64'(o_id_valid), 64'(valid));
    end
    pop = valid && rdy && !fl;
    if (rst || fl) begin
      sb.delete();
      nsize = 0;
    end else begin
      if (push) begin
        e.instr = i_instr;
        e.npc   = pc + NB_ADDR'(1);
        sb.push_back(e);
      end
      nsize = size + int'(push) - int'(pop);
    end
    if (push) pc = pc + NB_ADDR'(1);
    if (fl) pc = NB_ADDR'($urandom_range(0, 1000));
    if (rst)            m_st = 0;
    else if (m_st == 3) m_st = 3;
    else if (fl)        m_st = 2;
    else if (hl)        m_st = 3;
    else                m_st = (nsize == DEPTH) ? 1 : 0;
    if (rst) seen_reset = 1'b1;
  endtask

  // Monitor: compares every word decode accepts against the scoreboard head.
  initial begin
    entry_t e;
    while (!done) begin
      @(negedge i_clk);
      if (!i_reset && seen_reset) begin
        if (o_id_valid && i_id_ready && !i_flush) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_underflow actual=valid_handshake required=no_entry at %0t", $time);
          end else begin
            e = sb.pop_front();
            check("id_instr", 64'(o_id_instr), 64'(e.instr));
            check("id_npc", 64'(o_id_npc), 64'(e.npc));
          end
        end else if (!o_id_valid) begin
          check("idle_instr", 64'(o_id_instr), 64'd0);
          check("idle_npc", 64'(o_id_npc), 64'd0);
        end
      end
    end
  end

  initial begin
    i_reset     = 1'b1;
    i_mem_valid = 1'b0;
    i_flush     = 1'b0;
    i_halt      = 1'b0;
    i_id_ready  = 1'b0;
    i_pc_addr   = '0;
    i_instr     = '0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    pc = '0;

    // Streaming fetch with decode always ready.
    repeat (3) step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Fill to full and stall, single pop, one more push.
    repeat (6) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0, 0);

    // Full queue with concurrent pop: no push that cycle.
    step(0, 1, 0, 0, 1);

    // Flush with three entries queued and decode ready.
    step(0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);

    // Two entries queued, then halt; both drain, then reset.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 2) != 0);
    end

    repeat (DEPTH + 2) step(0, 0, 0, 0, 1);
    @(negedge i_clk);
    done = 1'b1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
